// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM.
package mc_ctrl_pkg;

  // Opcodes taken from instr[31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Encodings are visible on the debug state port, so keep them fixed.
  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExecute = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10
  } state_e;

  // ALU operation select.
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // Next-PC source select.
  localparam logic [1:0] PcAluRes = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

endpackage

// File: rtl/multicycle_controller_retire_counter.sv
// Retired-instruction counter: synchronous clear, increment enable, silent wrap.
module retire_counter #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [CntW-1:0] count_o
);

  logic [CntW-1:0] count_d, count_q;

  // Next count: clear dominates increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences shared memory, ALU and register file per instruction.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_e state_d, state_q;

  // Next state and control outputs; everything defaults to 0.
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBReg;
    alu_op        = AluAdd;
    pc_source     = PcAluRes;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        // PC+4 computed in parallel with the instruction read.
        mem_read  = 1'b1;
        alu_src_b = SrcBFour;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Speculative branch target into ALU-out.
        alu_src_b = SrcBImmSh;
        case (opcode)
          OP_RTYPE:    state_d = StExecute;
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_BEQ:      state_d = StBranch;
          OP_J:        state_d = StJump;
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = (opcode == OP_LW) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = StFetch;
      end
      StExecute: begin
        alu_src_a = 1'b1;
        alu_op    = AluFunct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = AluSub;
        pc_write_cond = 1'b1;
        pc_source     = PcAluOut;
        instr_done    = 1'b1;
        state_d       = StFetch;
      end
      StJump: begin
        pc_write   = 1'b1;
        pc_source  = PcJump;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      default: begin
        // Unused encodings recover through FETCH with outputs quiet.
        state_d = StFetch;
      end
    endcase

    // An abandoned instruction must not write anything in the reset cycle.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SrcBReg;
      alu_op        = AluAdd;
      pc_source     = PcAluRes;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  retire_counter #(
    .CntW (CNT_W)
  ) u_retire_counter (
    .clk_i   (clk),
    .clr_i   (reset),
    .inc_i   (instr_done),
    .count_o (retired)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with hand-computed control vectors.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] retired;
  logic [3:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  // Control vector: {pw pwc iord mr mw irw}_{m2r rd rw asa}_srcb_aluop_pcs_{done ill}
  localparam logic [17:0] CtlZero     = 18'b000000_0000_00_00_00_00;
  localparam logic [17:0] CtlFetchRdy = 18'b100101_0000_01_00_00_00;
  localparam logic [17:0] CtlFetchNr  = 18'b000100_0000_01_00_00_00;
  localparam logic [17:0] CtlDecode   = 18'b000000_0000_11_00_00_00;
  localparam logic [17:0] CtlDecIll   = 18'b000000_0000_11_00_00_01;
  localparam logic [17:0] CtlMemAdr   = 18'b000000_0001_10_00_00_00;
  localparam logic [17:0] CtlMemRd    = 18'b001100_0000_00_00_00_00;
  localparam logic [17:0] CtlMemWb    = 18'b000000_1010_00_00_00_10;
  localparam logic [17:0] CtlMemWrRdy = 18'b001010_0000_00_00_00_10;
  localparam logic [17:0] CtlMemWrNr  = 18'b001010_0000_00_00_00_00;
  localparam logic [17:0] CtlExecute  = 18'b000000_0001_00_10_00_00;
  localparam logic [17:0] CtlAluWb    = 18'b000000_0110_00_00_00_10;
  localparam logic [17:0] CtlBranch   = 18'b010000_0001_00_01_01_10;
  localparam logic [17:0] CtlJump     = 18'b100000_0000_00_00_10_10;

  logic [17:0] ctl;
  assign ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, illegal_op};

  multicycle_controller #(
    .CNT_W (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .retired       (retired),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs mid-cycle, check state and controls, then advance one edge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                     input logic [3:0] exp_state, input logic [17:0] exp_ctl);
    opcode    = op;
    mem_ready = rdy;
    #1;
    check_eq({tag, "_state"}, 64'(state), 64'(exp_state));
    check_eq({tag, "_ctl"}, 64'(ctl), 64'(exp_ctl));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'd0;
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_retired", 64'(retired), 64'd0);
    check_eq("rst_ctl", 64'(ctl), 64'(CtlZero));
    reset = 1'b0;

    // R-type, no wait states.
    cyc("r_idle", 6'd0, 1'b1, 4'd0, CtlZero);
    cyc("r_fetch", 6'd0, 1'b1, 4'd1, CtlFetchRdy);
    cyc("r_dec", 6'd0, 1'b1, 4'd2, CtlDecode);
    cyc("r_exe", 6'd0, 1'b1, 4'd7, CtlExecute);
    cyc("r_wb", 6'd0, 1'b1, 4'd8, CtlAluWb);
    check_eq("r_retired", 64'(retired), 64'd1);

    // lw with two memory wait cycles in MEMRD: 7 cycles.
    cyc("lw_fetch", 6'd35, 1'b1, 4'd1, CtlFetchRdy);
    cyc("lw_dec", 6'd35, 1'b1, 4'd2, CtlDecode);
    cyc("lw_adr", 6'd35, 1'b1, 4'd3, CtlMemAdr);
    cyc("lw_rd0", 6'd35, 1'b0, 4'd4, CtlMemRd);
    cyc("lw_rd1", 6'd35, 1'b0, 4'd4, CtlMemRd);
    cyc("lw_rd2", 6'd35, 1'b1, 4'd4, CtlMemRd);
    cyc("lw_wb", 6'd35, 1'b1, 4'd5, CtlMemWb);
    check_eq("lw_retired", 64'(retired), 64'd2);

    // sw, beq, j back to back: 10 cycles.
    cyc("sw_fetch", 6'd43, 1'b1, 4'd1, CtlFetchRdy);
    cyc("sw_dec", 6'd43, 1'b1, 4'd2, CtlDecode);
    cyc("sw_adr", 6'd43, 1'b1, 4'd3, CtlMemAdr);
    cyc("sw_wr", 6'd43, 1'b1, 4'd6, CtlMemWrRdy);
    cyc("beq_fetch", 6'd4, 1'b1, 4'd1, CtlFetchRdy);
    cyc("beq_dec", 6'd4, 1'b1, 4'd2, CtlDecode);
    cyc("beq_br", 6'd4, 1'b1, 4'd9, CtlBranch);
    cyc("j_fetch", 6'd2, 1'b1, 4'd1, CtlFetchRdy);
    cyc("j_dec", 6'd2, 1'b1, 4'd2, CtlDecode);
    cyc("j_jump", 6'd2, 1'b1, 4'd10, CtlJump);
    check_eq("sbj_retired", 64'(retired), 64'd5);

    // FETCH stalled three cycles, then an illegal opcode.
    cyc("fst_nr0", 6'd63, 1'b0, 4'd1, CtlFetchNr);
    cyc("fst_nr1", 6'd63, 1'b0, 4'd1, CtlFetchNr);
    cyc("fst_nr2", 6'd63, 1'b0, 4'd1, CtlFetchNr);
    cyc("fst_rdy", 6'd63, 1'b1, 4'd1, CtlFetchRdy);
    cyc("ill_dec", 6'd63, 1'b1, 4'd2, CtlDecIll);
    check_eq("ill_retired", 64'(retired), 64'd5);

    // sw stalled in MEMWR, then reset hits mid-instruction.
    cyc("rs_fetch", 6'd43, 1'b1, 4'd1, CtlFetchRdy);
    cyc("rs_dec", 6'd43, 1'b1, 4'd2, CtlDecode);
    cyc("rs_adr", 6'd43, 1'b1, 4'd3, CtlMemAdr);
    cyc("rs_wr_nr", 6'd43, 1'b0, 4'd6, CtlMemWrNr);
    reset     = 1'b1;
    mem_ready = 1'b0;
    #1;
    check_eq("rs_cycle_ctl", 64'(ctl), 64'(CtlZero));
    check_eq("rs_cycle_mem_write", 64'(mem_write), 64'd0);
    @(posedge clk);
    #1;
    check_eq("rs_after_state", 64'(state), 64'd0);
    check_eq("rs_after_retired", 64'(retired), 64'd0);
    reset = 1'b0;
    cyc("rs_idle", 6'd43, 1'b0, 4'd0, CtlZero);
    cyc("rs_resume", 6'd43, 1'b0, 4'd1, CtlFetchNr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
